// File: rtl/memshare_vn_lane_array.sv
// memshare_vn_lane_array
//   VN group for the memory-share layered IB-LDPC decoder. Shifted C2V
//   messages are pushed through per-lane, runtime-remappable IB-LUT tables.
//   Each result's sign is merged with the buffered V2C sign from the previous
//   layer, and the V2C vector is emitted for write-back.
//   The block has valid/ready input flow control and a V2C sign FIFO. Lanes can
//   be masked. A drain-then-remap FSM lets the IB tables be reloaded between
//   decoding phases.
//
// Ports
//   sys_clk, rstn        clock (rising edge), async active-low reset
//   c2v_vec_i/valid/rdy  shifted C2V vector, lane i at [i*Q +: Q], handshake
//   col_sel_vec_i        per-lane table select, sampled with C2V
//   lane_en_i            per-lane enable, sampled with C2V
//   v2c_sign_vec_i/push  V2C sign vector into the sign FIFO
//   sign_full_o          sign FIFO full
//   v2c_msg_vec_o/valid  V2C result vector, valid for one cycle per vector
//   remap_en_i           request / continue an IB-LUT remap session
//   remap_lane/addr/data LUT write target {col_sel, mag} and new magnitude
//   remap_done_o         one-cycle pulse when a remap session ends
//   sign_ovf_o           sticky: sign push dropped because the FIFO was full
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | after reset or remap; waits for remap_en_i low
// RUN    | accepting C2V vectors
// DRAIN  | remap requested; no accepts, waiting for pipeline to empty
// REMAP  | pipeline empty; one LUT write per cycle while remap_en_i high

module memshare_vn_lane_array #(
  parameter int SHARE_GROUP_SIZE   = 5,
  parameter int QUAN_SIZE          = 4,
  parameter int COL_SEL_WIDTH      = 2,
  parameter int V2C_SIGN_BUF_DEPTH = 2,
  localparam int MAG_WIDTH         = QUAN_SIZE - 1,
  localparam int LUT_ADDR_WIDTH    = COL_SEL_WIDTH + MAG_WIDTH,
  localparam int LANE_W            = (SHARE_GROUP_SIZE > 1) ? $clog2(SHARE_GROUP_SIZE) : 1
) (
  input  logic                                      sys_clk,
  input  logic                                      rstn,
  input  logic [SHARE_GROUP_SIZE*QUAN_SIZE-1:0]     c2v_vec_i,
  input  logic                                      c2v_valid_i,
  output logic                                      c2v_ready_o,
  input  logic [SHARE_GROUP_SIZE*COL_SEL_WIDTH-1:0] col_sel_vec_i,
  input  logic [SHARE_GROUP_SIZE-1:0]               lane_en_i,
  input  logic [SHARE_GROUP_SIZE-1:0]               v2c_sign_vec_i,
  input  logic                                      v2c_sign_push_i,
  output logic                                      sign_full_o,
  output logic [SHARE_GROUP_SIZE*QUAN_SIZE-1:0]     v2c_msg_vec_o,
  output logic                                      v2c_valid_o,
  input  logic                                      remap_en_i,
  input  logic [LANE_W-1:0]                         remap_lane_i,
  input  logic [LUT_ADDR_WIDTH-1:0]                 remap_addr_i,
  input  logic [MAG_WIDTH-1:0]                      remap_data_i,
  output logic                                      remap_done_o,
  output logic                                      sign_ovf_o
);

  localparam int VEC_W     = SHARE_GROUP_SIZE * QUAN_SIZE;
  localparam int COL_W     = SHARE_GROUP_SIZE * COL_SEL_WIDTH;
  localparam int LUT_DEPTH = 1 << LUT_ADDR_WIDTH;
  localparam int PTR_W     = (V2C_SIGN_BUF_DEPTH > 1) ? $clog2(V2C_SIGN_BUF_DEPTH) : 1;
  localparam int CNT_W     = $clog2(V2C_SIGN_BUF_DEPTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_REMAP
  } state_t;

  state_t state;

  // Sign FIFO
  logic [SHARE_GROUP_SIZE-1:0] fifo_mem [V2C_SIGN_BUF_DEPTH];
  logic [PTR_W-1:0]            wr_ptr;
  logic [PTR_W-1:0]            rd_ptr;
  logic [CNT_W-1:0]            sign_cnt;
  logic                        fifo_empty;
  logic                        accept;
  logic                        pop;
  logic                        push_ok;

  // Stage 0 registers
  logic                        s0_vld;
  logic [VEC_W-1:0]            s0_c2v;
  logic [COL_W-1:0]            s0_col;
  logic [SHARE_GROUP_SIZE-1:0] s0_en;
  logic [SHARE_GROUP_SIZE-1:0] s0_sign;

  // LUT storage and per-lane result
  logic [MAG_WIDTH-1:0]        lut [SHARE_GROUP_SIZE][LUT_DEPTH];
  logic                        lut_we;
  logic [VEC_W-1:0]            lane_res;

  assign fifo_empty  = (sign_cnt == '0);
  assign sign_full_o = (sign_cnt == CNT_W'(V2C_SIGN_BUF_DEPTH));
  assign c2v_ready_o = (state == ST_RUN) && !fifo_empty && !remap_en_i;
  assign accept      = c2v_valid_i && c2v_ready_o;
  assign pop         = accept;
  // A push into a full FIFO still fits when the same cycle pops an entry.
  assign push_ok     = v2c_sign_push_i && (!sign_full_o || pop);

  // Writes only land in REMAP, which is entered once stage 0 is empty.
  // No LUT read and write can therefore happen in the same cycle.
  assign lut_we      = (state == ST_REMAP) && remap_en_i;

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      state        <= ST_IDLE;
      remap_done_o <= 1'b0;
    end else begin
      remap_done_o <= 1'b0;
      unique case (state)
        ST_IDLE:  if (!remap_en_i) state <= ST_RUN;
        ST_RUN:   if (remap_en_i) state <= ST_DRAIN;
        ST_DRAIN: if (!s0_vld && !v2c_valid_o) state <= ST_REMAP;
        ST_REMAP: begin
          if (!remap_en_i) begin
            state        <= ST_IDLE;
            remap_done_o <= 1'b1;
          end
        end
        default:  state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      sign_cnt   <= '0;
      sign_ovf_o <= 1'b0;
      for (int e = 0; e < V2C_SIGN_BUF_DEPTH; e++) fifo_mem[e] <= '0;
    end else begin
      if (push_ok) begin
        fifo_mem[wr_ptr] <= v2c_sign_vec_i;
        wr_ptr <= (wr_ptr == PTR_W'(V2C_SIGN_BUF_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_W'(V2C_SIGN_BUF_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      end
      if (v2c_sign_push_i && !push_ok) sign_ovf_o <= 1'b1;
      unique case ({push_ok, pop})
        2'b10:   sign_cnt <= sign_cnt + CNT_W'(1);
        2'b01:   sign_cnt <= sign_cnt - CNT_W'(1);
        default: sign_cnt <= sign_cnt;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      s0_vld  <= 1'b0;
      s0_c2v  <= '0;
      s0_col  <= '0;
      s0_en   <= '0;
      s0_sign <= '0;
    end else begin
      s0_vld <= accept;
      if (accept) begin
        s0_c2v  <= c2v_vec_i;
        s0_col  <= col_sel_vec_i;
        s0_en   <= lane_en_i;
        s0_sign <= fifo_mem[rd_ptr];
      end
    end
  end

  // Reset restores the identity mapping: entry[{c, m}] = m.
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      for (int l = 0; l < SHARE_GROUP_SIZE; l++) begin
        for (int a = 0; a < LUT_DEPTH; a++) begin
          lut[l][a] <= MAG_WIDTH'(a);
        end
      end
    end else if (lut_we) begin
      // Lane indices at or above SHARE_GROUP_SIZE match nothing.
      for (int l = 0; l < SHARE_GROUP_SIZE; l++) begin
        if (remap_lane_i == LANE_W'(l)) lut[l][remap_addr_i] <= remap_data_i;
      end
    end
  end

  for (genvar g = 0; g < SHARE_GROUP_SIZE; g++) begin : g_lane
    logic [MAG_WIDTH-1:0]     c_mag;
    logic                     c_sgn;
    logic [COL_SEL_WIDTH-1:0] col;
    logic [MAG_WIDTH-1:0]     mag;
    logic                     sgn;

    assign c_mag = s0_c2v[g*QUAN_SIZE +: MAG_WIDTH];
    assign c_sgn = s0_c2v[g*QUAN_SIZE + QUAN_SIZE - 1];
    assign col   = s0_col[g*COL_SEL_WIDTH +: COL_SEL_WIDTH];
    assign mag   = lut[g][{col, c_mag}];
    assign sgn   = c_sgn ^ s0_sign[g];
    // A zero magnitude always carries a positive sign.
    assign lane_res[g*QUAN_SIZE +: QUAN_SIZE] = s0_en[g] ? {sgn & (|mag), mag} : '0;
  end

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      v2c_valid_o   <= 1'b0;
      v2c_msg_vec_o <= '0;
    end else begin
      v2c_valid_o <= s0_vld;
      if (s0_vld) v2c_msg_vec_o <= lane_res;
    end
  end

endmodule

// File: tb/tb_memshare_vn_lane_array.sv
module tb_memshare_vn_lane_array;

  localparam int SGS   = 5;
  localparam int Q     = 4;
  localparam int CW    = 2;
  localparam int DEPTH = 2;
  localparam int MW    = Q - 1;
  localparam int AW    = CW + MW;
  localparam int LD    = 1 << AW;
  localparam int LW    = 3;
  localparam int W     = SGS * Q;

  logic             sys_clk = 1'b0;
  logic             rstn    = 1'b0;
  logic [W-1:0]     c2v_vec;
  logic             c2v_valid;
  logic [SGS*CW-1:0] col_sel;
  logic [SGS-1:0]   lane_en;
  logic [SGS-1:0]   sign_vec;
  logic             sign_push;
  logic             remap_en;
  logic [LW-1:0]    remap_lane;
  logic [AW-1:0]    remap_addr;
  logic [MW-1:0]    remap_data;

  logic             c2v_ready;
  logic             sign_full;
  logic [W-1:0]     v2c_msg;
  logic             v2c_valid;
  logic             remap_done;
  logic             sign_ovf;

  memshare_vn_lane_array #(
    .SHARE_GROUP_SIZE  (SGS),
    .QUAN_SIZE         (Q),
    .COL_SEL_WIDTH     (CW),
    .V2C_SIGN_BUF_DEPTH(DEPTH)
  ) dut (
    .sys_clk        (sys_clk),
    .rstn           (rstn),
    .c2v_vec_i      (c2v_vec),
    .c2v_valid_i    (c2v_valid),
    .c2v_ready_o    (c2v_ready),
    .col_sel_vec_i  (col_sel),
    .lane_en_i      (lane_en),
    .v2c_sign_vec_i (sign_vec),
    .v2c_sign_push_i(sign_push),
    .sign_full_o    (sign_full),
    .v2c_msg_vec_o  (v2c_msg),
    .v2c_valid_o    (v2c_valid),
    .remap_en_i     (remap_en),
    .remap_lane_i   (remap_lane),
    .remap_addr_i   (remap_addr),
    .remap_data_i   (remap_data),
    .remap_done_o   (remap_done),
    .sign_ovf_o     (sign_ovf)
  );

  always #5 sys_clk = ~sys_clk;

  // Reference model: sign FIFO as a queue, outputs as a due-cycle queue,
  // LUT contents as plain integers.
  typedef struct {
    int           due;
    logic [W-1:0] vec;
  } out_t;

  int           n_tests = 0;
  int           n_fail  = 0;
  int           cyc     = 0;
  bit           model_run = 0;
  bit           ovf_m     = 0;
  bit           chk_done  = 1;
  bit           saw_done  = 0;
  logic [W-1:0] exp_vec   = '0;
  logic [SGS-1:0] sq[$];
  out_t         oq[$];
  int           lut_m [SGS][LD];

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] model_vec(input logic [W-1:0] c2v,
                                             input logic [SGS*CW-1:0] col,
                                             input logic [SGS-1:0] en,
                                             input logic [SGS-1:0] sg);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < SGS; i++) begin
      int qv;
      int m;
      int s;
      int c;
      int mag;
      int sn;
      qv  = int'(c2v[i*Q +: Q]);
      m   = qv % (1 << MW);
      s   = qv / (1 << MW);
      c   = int'(col[i*CW +: CW]);
      mag = lut_m[i][c * (1 << MW) + m];
      sn  = (s + int'(sg[i])) % 2;
      if (en[i] && mag != 0) r[i*Q +: Q] = Q'(sn * (1 << MW) + mag);
    end
    return r;
  endfunction

  task automatic model_reset();
    sq.delete();
    oq.delete();
    exp_vec   = '0;
    ovf_m     = 0;
    model_run = 0;
    for (int l = 0; l < SGS; l++)
      for (int a = 0; a < LD; a++) lut_m[l][a] = a % (1 << MW);
  endtask

  task automatic set_idle();
    c2v_valid  = 0;
    c2v_vec    = '0;
    col_sel    = '0;
    lane_en    = '1;
    sign_vec   = '0;
    sign_push  = 0;
    remap_en   = 0;
    remap_lane = '0;
    remap_addr = '0;
    remap_data = '0;
  endtask

  // One clock cycle: inputs already driven (clock low).
  task automatic step();
    bit           exp_rdy;
    bit           exp_valid;
    logic [SGS-1:0] sgn;
    out_t         o;
    #1;
    exp_rdy = model_run && (sq.size() > 0) && !remap_en;
    chk_eq("c2v_ready", c2v_ready, exp_rdy);
    if (c2v_valid && exp_rdy) begin
      sgn   = sq.pop_front();
      o.due = cyc + 2;
      o.vec = model_vec(c2v_vec, col_sel, lane_en, sgn);
      oq.push_back(o);
    end
    if (sign_push) begin
      if (sq.size() < DEPTH) sq.push_back(sign_vec);
      else ovf_m = 1;
    end
    @(posedge sys_clk);
    cyc++;
    #1;
    exp_valid = 0;
    if (oq.size() > 0 && oq[0].due == cyc) begin
      o         = oq.pop_front();
      exp_valid = 1;
      exp_vec   = o.vec;
    end
    chk_eq("v2c_valid", v2c_valid, exp_valid);
    chk_eq("v2c_msg", v2c_msg, exp_vec);
    chk_eq("sign_full", sign_full, sq.size() == DEPTH);
    chk_eq("sign_ovf", sign_ovf, ovf_m);
    if (chk_done) chk_eq("remap_done_idle", remap_done, 0);
    saw_done = remap_done;
    @(negedge sys_clk);
  endtask

  task automatic remap_session(input int lane, input int addr, input int data);
    bit seen;
    seen       = 0;
    model_run  = 0;
    chk_done   = 0;
    c2v_valid  = 0;
    sign_push  = 0;
    remap_en   = 1;
    remap_lane = LW'(lane);
    remap_addr = AW'(addr);
    remap_data = MW'(data);
    repeat (6) step();
    if (lane < SGS) lut_m[lane][addr] = data;
    remap_en = 0;
    for (int k = 0; k < 4 && !seen; k++) begin
      step();
      if (saw_done) seen = 1;
    end
    chk_eq("remap_done_pulse", seen, 1);
    chk_done = 1;
    step();
    model_run = 1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk_eq({tag, "_msg"}, v2c_msg, 0);
    chk_eq({tag, "_valid"}, v2c_valid, 0);
    chk_eq({tag, "_ready"}, c2v_ready, 0);
    chk_eq({tag, "_done"}, remap_done, 0);
    chk_eq({tag, "_ovf"}, sign_ovf, 0);
    chk_eq({tag, "_full"}, sign_full, 0);
  endtask

  task automatic rand_inputs();
    c2v_valid = ($urandom_range(0, 9) < 7);
    c2v_vec   = W'($urandom);
    col_sel   = (SGS*CW)'($urandom);
    lane_en   = ($urandom_range(0, 3) == 0) ? SGS'($urandom) : '1;
    sign_push = ($urandom_range(0, 9) < 6);
    sign_vec  = SGS'($urandom);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit [5:0] pat;
    set_idle();
    model_reset();
    repeat (2) @(negedge sys_clk);
    check_reset_outputs("reset");
    rstn = 1;

    // 1: identity path, lane0 = 0011
    sign_push = 1; sign_vec = 5'b00000;
    step();
    model_run = 1;
    set_idle();
    c2v_valid = 1; c2v_vec = 20'h00003;
    step();
    set_idle();
    step();
    chk_eq("t1_valid", v2c_valid, 1);
    chk_eq("t1_vec", v2c_msg, 20'h00003);
    step();
    chk_eq("t1_pulse", v2c_valid, 0);

    // 2: sign merge and zero-sign rule
    sign_push = 1; sign_vec = 5'b00001;
    step();
    set_idle();
    c2v_valid = 1; c2v_vec = 20'h0000A;
    step();
    set_idle();
    step();
    chk_eq("t2_merge", v2c_msg, 20'h00002);
    sign_push = 1; sign_vec = 5'b00001;
    step();
    set_idle();
    c2v_valid = 1; c2v_vec = 20'h11118;
    step();
    set_idle();
    step();
    chk_eq("t2_zero_sign", v2c_msg, 20'h11110);

    // 3: overflow and push+pop while full
    sign_push = 1; sign_vec = 5'b00011; step();
    sign_vec = 5'b00101; step();
    chk_eq("t3_full", sign_full, 1);
    chk_eq("t3_no_ovf", sign_ovf, 0);
    sign_vec = 5'b11111; step();
    chk_eq("t3_ovf", sign_ovf, 1);
    sign_vec = 5'b01000; c2v_valid = 1; c2v_vec = 20'h99999;
    step();
    chk_eq("t3_full_after_pushpop", sign_full, 1);
    sign_push = 0;
    repeat (2) step();
    set_idle();
    repeat (3) step();

    // 4: back-to-back accepts, then empty FIFO blocks
    sign_push = 1; sign_vec = 5'b10101; step();
    sign_vec = 5'b01010; step();
    pat = '0;
    for (int k = 0; k < 6; k++) begin
      c2v_valid = 1;
      c2v_vec   = W'($urandom);
      col_sel   = (SGS*CW)'($urandom);
      sign_push = (k < 2);
      sign_vec  = SGS'($urandom);
      step();
      pat[k] = v2c_valid;
    end
    chk_eq("t4_valid_pattern", pat, 6'b011110);
    set_idle();
    step();

    // 5: remap with two vectors in flight
    sign_push = 1; sign_vec = 5'b00000; step();
    sign_vec = 5'b00000; step();
    sign_push = 0;
    c2v_valid = 1; c2v_vec = 20'h12345; step();
    c2v_vec = 20'h54321; step();
    remap_session(2, 5'b01011, 3'b110);
    set_idle();
    sign_push = 1; sign_vec = 5'b00000; step();
    set_idle();
    c2v_valid = 1; c2v_vec = 20'h00300; col_sel = 10'h010; step();
    set_idle();
    step();
    chk_eq("t5_remapped", v2c_msg, 20'h00600);

    // Random traffic with periodic remap sessions (lanes 0..7)
    for (int k = 0; k < 400; k++) begin
      rand_inputs();
      step();
      if (k % 100 == 50) begin
        remap_session($urandom_range(0, 7), $urandom_range(0, LD - 1),
                      $urandom_range(0, (1 << MW) - 1));
      end
    end

    // 6: mid-stream reset
    rand_inputs();
    c2v_valid = 1;
    step();
    rand_inputs();
    step();
    rstn = 0;
    #1;
    check_reset_outputs("midreset");
    model_reset();
    set_idle();
    @(negedge sys_clk);
    @(negedge sys_clk);
    rstn = 1;
    step();
    model_run = 1;
    sign_push = 1; sign_vec = 5'b00000; step();
    set_idle();
    c2v_valid = 1; c2v_vec = 20'h00300; col_sel = 10'h010; step();
    set_idle();
    step();
    chk_eq("t6_identity", v2c_msg, 20'h00300);
    repeat (2) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
